// File: rtl/axi4lite_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_rd_arbiter
// Description : Shares one AXI4-Lite slave read port (AR/R) between an
//               instruction-fetch master (M0) and a load master (M1).
//               Round-robin grant per transaction, one read outstanding.
//               R channel is a zero-latency combinational passthrough.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2
) (
  input  logic                  iClock,
  input  logic                  iReset,
  // M0 : instruction fetch
  input  logic                  pM0_ar_valid,
  input  logic [ADDR_WIDTH-1:0] pM0_ar_bits_addr,
  output logic                  pM0_ar_ready,
  input  logic                  pM0_r_ready,
  output logic                  pM0_r_valid,
  output logic [DATA_WIDTH-1:0] pM0_r_bits_data,
  output logic [RESP_WIDTH-1:0] pM0_r_bits_resp,
  // M1 : load
  input  logic                  pM1_ar_valid,
  input  logic [ADDR_WIDTH-1:0] pM1_ar_bits_addr,
  output logic                  pM1_ar_ready,
  input  logic                  pM1_r_ready,
  output logic                  pM1_r_valid,
  output logic [DATA_WIDTH-1:0] pM1_r_bits_data,
  output logic [RESP_WIDTH-1:0] pM1_r_bits_resp,
  // Shared slave port
  output logic                  pS_ar_valid,
  output logic [ADDR_WIDTH-1:0] pS_ar_bits_addr,
  input  logic                  pS_ar_ready,
  input  logic                  pS_r_valid,
  input  logic [DATA_WIDTH-1:0] pS_r_bits_data,
  input  logic [RESP_WIDTH-1:0] pS_r_bits_resp,
  output logic                  pS_r_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_grant;   // master owning the current transaction
  logic                  r_last;    // master served most recently
  logic                  r_live;    // first edge after reset release seen
  logic [ADDR_WIDTH-1:0] r_addr;

  logic                  w_win_valid;
  logic                  w_win;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_r_ready;

  // Slave address always comes from the latched request
  assign pS_ar_bits_addr = r_addr;

  // Round-robin winner among the requesting masters; a tie goes to the one not served last
  always_comb begin
    w_win_valid = pM0_ar_valid | pM1_ar_valid;
    w_win       = 1'b0;
    if (pM0_ar_valid && pM1_ar_valid) begin
      w_win = ~r_last;
    end else if (pM1_ar_valid) begin
      w_win = 1'b1;
    end
  end

  // Next-state and all handshake / passthrough outputs
  always_comb begin
    w_state_next    = r_state;
    w_ar_hs         = 1'b0;
    w_r_hs          = 1'b0;
    w_r_ready       = 1'b0;
    pM0_ar_ready    = 1'b0;
    pM1_ar_ready    = 1'b0;
    pM0_r_valid     = 1'b0;
    pM1_r_valid     = 1'b0;
    pM0_r_bits_data = '0;
    pM1_r_bits_data = '0;
    pM0_r_bits_resp = '0;
    pM1_r_bits_resp = '0;
    pS_ar_valid     = 1'b0;
    pS_r_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_live && w_win_valid) begin
          pM0_ar_ready = ~w_win;
          pM1_ar_ready = w_win;
          w_ar_hs      = 1'b1;
          w_state_next = ADDR;
        end
      end
      ADDR: begin
        pS_ar_valid = 1'b1;
        if (pS_ar_ready) begin
          w_state_next = DATA;
        end
      end
      DATA: begin
        w_r_ready  = r_grant ? pM1_r_ready : pM0_r_ready;
        pS_r_ready = w_r_ready;
        if (r_grant) begin
          pM1_r_valid     = pS_r_valid;
          pM1_r_bits_data = pS_r_bits_data;
          pM1_r_bits_resp = pS_r_bits_resp;
        end else begin
          pM0_r_valid     = pS_r_valid;
          pM0_r_bits_data = pS_r_bits_data;
          pM0_r_bits_resp = pS_r_bits_resp;
        end
        if (pS_r_valid && w_r_ready) begin
          w_r_hs       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Grant, fairness history, latched address and post-reset enable
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_live  <= 1'b0;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_addr  <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_ar_hs) begin
        r_grant <= w_win;
        r_addr  <= w_win ? pM1_ar_bits_addr : pM0_ar_bits_addr;
      end
      if (w_r_hs) begin
        r_last <= r_grant;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4lite_rd_arbiter
// Description : Randomized bench for axi4lite_rd_arbiter against a
//               transaction-level model of masters, slave and arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4lite_rd_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int RW = 2;

  logic          iClock = 1'b0;
  logic          iReset = 1'b0;
  logic          pM0_ar_valid = 1'b0;
  logic [AW-1:0] pM0_ar_bits_addr = '0;
  logic          pM0_ar_ready;
  logic          pM0_r_ready = 1'b0;
  logic          pM0_r_valid;
  logic [DW-1:0] pM0_r_bits_data;
  logic [RW-1:0] pM0_r_bits_resp;
  logic          pM1_ar_valid = 1'b0;
  logic [AW-1:0] pM1_ar_bits_addr = '0;
  logic          pM1_ar_ready;
  logic          pM1_r_ready = 1'b0;
  logic          pM1_r_valid;
  logic [DW-1:0] pM1_r_bits_data;
  logic [RW-1:0] pM1_r_bits_resp;
  logic          pS_ar_valid;
  logic [AW-1:0] pS_ar_bits_addr;
  logic          pS_ar_ready = 1'b0;
  logic          pS_r_valid = 1'b0;
  logic [DW-1:0] pS_r_bits_data = '0;
  logic [RW-1:0] pS_r_bits_resp = '0;
  logic          pS_r_ready;

  axi4lite_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_WIDTH(RW)) u_dut (
    .iClock(iClock), .iReset(iReset),
    .pM0_ar_valid(pM0_ar_valid), .pM0_ar_bits_addr(pM0_ar_bits_addr), .pM0_ar_ready(pM0_ar_ready),
    .pM0_r_ready(pM0_r_ready), .pM0_r_valid(pM0_r_valid), .pM0_r_bits_data(pM0_r_bits_data),
    .pM0_r_bits_resp(pM0_r_bits_resp),
    .pM1_ar_valid(pM1_ar_valid), .pM1_ar_bits_addr(pM1_ar_bits_addr), .pM1_ar_ready(pM1_ar_ready),
    .pM1_r_ready(pM1_r_ready), .pM1_r_valid(pM1_r_valid), .pM1_r_bits_data(pM1_r_bits_data),
    .pM1_r_bits_resp(pM1_r_bits_resp),
    .pS_ar_valid(pS_ar_valid), .pS_ar_bits_addr(pS_ar_bits_addr), .pS_ar_ready(pS_ar_ready),
    .pS_r_valid(pS_r_valid), .pS_r_bits_data(pS_r_bits_data), .pS_r_bits_resp(pS_r_bits_resp),
    .pS_r_ready(pS_r_ready)
  );

  always #5 iClock = ~iClock;

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus knobs (percent probabilities)
  int p_req[2];
  int p_drop, p_sar, p_srv, p_rr, p_spur;
  bit fix_en, use_force, rst_hold;
  logic [AW-1:0] fix_addr[2];
  logic [DW-1:0] force_data;
  logic [RW-1:0] force_resp;

  // Master agents
  bit            req[2];
  logic [AW-1:0] req_addr[2];
  bit            vld[2];
  bit            rrdy[2];

  // Slave agent
  bit            s_pend;
  bit            s_rv;
  logic [DW-1:0] s_data;
  logic [RW-1:0] s_resp;

  // Reference model: who owns the port and how far its read has progressed
  bit            m_live, m_busy, m_sent, m_gnt, m_last;
  logic [AW-1:0] m_addr;
  bit            grants[$];

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit roll(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  // Which master should see ar_ready this cycle, derived from the fairness rule
  function automatic bit [1:0] exp_ar_ready();
    bit [1:0] e;
    bit       who;
    e = 2'b00;
    if (m_live && !m_busy && (vld[0] || vld[1])) begin
      if (vld[0] && vld[1]) who = (m_last == 1'b1) ? 1'b0 : 1'b1;
      else                  who = vld[1];
      e[who] = 1'b1;
    end
    return e;
  endfunction

  task automatic model_reset();
    m_live = 1'b0; m_busy = 1'b0; m_sent = 1'b0; m_gnt = 1'b0; m_last = 1'b1;
    m_addr = '0; s_pend = 1'b0; s_rv = 1'b0; req[0] = 1'b0; req[1] = 1'b0;
  endtask

  task automatic drive();
    iReset = rst_hold ? 1'b0 : 1'b1;
    for (int x = 0; x < 2; x++) begin
      if (!req[x] && !(m_busy && (m_gnt == x[0])) && roll(p_req[x])) begin
        req[x]      = 1'b1;
        req_addr[x] = fix_en ? fix_addr[x] : ($urandom & 32'hFFFF_FFF8);
      end
      vld[x]  = req[x] && !roll(p_drop);
      rrdy[x] = roll(p_rr);
    end
    pM0_ar_valid = vld[0]; pM0_ar_bits_addr = req_addr[0]; pM0_r_ready = rrdy[0];
    pM1_ar_valid = vld[1]; pM1_ar_bits_addr = req_addr[1]; pM1_r_ready = rrdy[1];
    pS_ar_ready = roll(p_sar);
    if (s_pend) begin
      if (!s_rv && roll(p_srv)) s_rv = 1'b1;
      pS_r_valid     = s_rv;
      pS_r_bits_data = s_data;
      pS_r_bits_resp = s_resp;
    end else begin
      // unsolicited data must be ignored
      pS_r_valid     = roll(p_spur);
      pS_r_bits_data = {$urandom, $urandom};
      pS_r_bits_resp = 2'($urandom);
    end
  endtask

  task automatic check_cycle();
    bit [1:0] e;
    bit       dph;
    e   = exp_ar_ready();
    dph = m_busy && m_sent;
    check_val("m0_ar_ready", 64'(pM0_ar_ready), 64'(e[0]));
    check_val("m1_ar_ready", 64'(pM1_ar_ready), 64'(e[1]));
    check_val("s_ar_valid",  64'(pS_ar_valid),  64'(m_busy && !m_sent));
    check_val("s_ar_addr",   64'(pS_ar_bits_addr), 64'(m_addr));
    check_val("s_r_ready",   64'(pS_r_ready),   64'(dph && rrdy[m_gnt]));
    check_val("m0_r_valid",  64'(pM0_r_valid),  64'((dph && !m_gnt) ? pS_r_valid : 1'b0));
    check_val("m1_r_valid",  64'(pM1_r_valid),  64'((dph &&  m_gnt) ? pS_r_valid : 1'b0));
    check_val("m0_r_data",   pM0_r_bits_data,   (dph && !m_gnt) ? pS_r_bits_data : 64'd0);
    check_val("m1_r_data",   pM1_r_bits_data,   (dph &&  m_gnt) ? pS_r_bits_data : 64'd0);
    check_val("m0_r_resp",   64'(pM0_r_bits_resp), 64'((dph && !m_gnt) ? pS_r_bits_resp : 2'd0));
    check_val("m1_r_resp",   64'(pM1_r_bits_resp), 64'((dph &&  m_gnt) ? pS_r_bits_resp : 2'd0));
  endtask

  // Advance the model to what the coming rising edge should commit
  task automatic update();
    bit [1:0] e;
    bit       hs_sa, hs_r;
    if (!iReset) begin
      model_reset();
      return;
    end
    e     = exp_ar_ready();
    hs_sa = m_busy && !m_sent && pS_ar_ready;
    hs_r  = m_busy && m_sent && pS_r_valid && rrdy[m_gnt];
    if (hs_r) begin
      check_val("e2e_data", m_gnt ? pM1_r_bits_data : pM0_r_bits_data, s_data);
      check_val("e2e_resp", 64'(m_gnt ? pM1_r_bits_resp : pM0_r_bits_resp), 64'(s_resp));
      m_busy = 1'b0; m_last = m_gnt; s_pend = 1'b0; s_rv = 1'b0;
    end
    if (hs_sa) begin
      m_sent = 1'b1; s_pend = 1'b1; s_rv = 1'b0;
      s_data = use_force ? force_data : {$urandom, $urandom};
      s_resp = use_force ? force_resp : 2'($urandom);
    end
    for (int x = 0; x < 2; x++) begin
      if (e[x] && vld[x]) begin
        m_busy = 1'b1; m_sent = 1'b0; m_gnt = x[0];
        m_addr = req_addr[x]; req[x] = 1'b0;
        grants.push_back(x[0]);
      end
    end
    m_live = 1'b1;
  endtask

  task automatic step();
    @(negedge iClock);
    drive();
    #1;
    check_cycle();
    update();
  endtask

  initial begin
    bit found;
    p_req[0] = 100; p_req[1] = 100; p_drop = 0; p_sar = 100; p_srv = 100;
    p_rr = 100; p_spur = 100; fix_en = 1'b0; use_force = 1'b0; rst_hold = 1'b1;
    fix_addr[0] = 32'h8000_0000; fix_addr[1] = 32'h8000_1000;
    force_data = 64'h0000_0013_0000_0297; force_resp = 2'b00;
    model_reset();

    // Held in reset with every input busy: outputs must stay quiet
    repeat (3) step();

    // Both masters requesting continuously from release: strict alternation, M0 first
    p_spur = 0; rst_hold = 1'b0; grants.delete();
    repeat (25) step();
    check_val("rr_count", 64'(grants.size()), 64'd8);
    for (int i = 0; i < grants.size(); i++) check_val("rr_order", 64'(grants[i]), 64'(i % 2));

    // Drain, then M0 alone at a fixed address with a fixed OKAY response
    p_req[0] = 0; p_req[1] = 0;
    repeat (6) step();
    p_req[0] = 100; fix_en = 1'b1; use_force = 1'b1; p_srv = 40;
    repeat (15) step();

    // M1 alone, slow slave, SLVERR response, hesitant r_ready
    p_req[0] = 0; p_req[1] = 100; force_resp = 2'b10;
    p_sar = 15; p_srv = 50; p_rr = 25;
    repeat (60) step();

    // Fully random traffic with dropped requests and unsolicited slave data
    fix_en = 1'b0; use_force = 1'b0; p_req[0] = 60; p_req[1] = 60;
    p_drop = 30; p_sar = 50; p_srv = 50; p_rr = 60; p_spur = 30;
    repeat (3000) step();

    // Reach the data phase with slave data waiting, then reset asynchronously
    p_req[0] = 100; p_req[1] = 0; p_drop = 0; p_sar = 100; p_srv = 100;
    p_rr = 0; p_spur = 0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (m_busy && m_sent && s_rv) found = 1'b1;
    end
    check_val("reach_data", 64'(found), 64'd1);
    @(negedge iClock);
    drive();
    #1;
    check_cycle();
    #1;
    iReset = 1'b0; rst_hold = 1'b1; model_reset();
    #1;
    check_cycle();
    p_req[1] = 100; p_rr = 100;
    repeat (2) step();
    rst_hold = 1'b0; grants.delete();
    repeat (2) step();
    check_val("post_rst_cnt", 64'(grants.size()), 64'd1);
    if (grants.size() > 0) check_val("post_rst_m0", 64'(grants[0]), 64'd0);
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi4lite_rd_arbiter.md
Name: axi4lite_rd_arbiter

Overview:
- Shares one AXI4-Lite slave read port (AR/R) between two read masters: M0 (IFU instruction fetch) and M1 (LSU load).
- Sits between the two fetch/load AXI4-Lite master interfaces and the single AXI4-Lite slave memory front end.
- Round-robin grant per transaction, one outstanding read at a time.
- LSU write channels (AW/W/B) bypass this block.

Parameters:
ADDR_WIDTH, 32, AR address width
DATA_WIDTH, 64, R data width
RESP_WIDTH, 2, R response width

Ports:
iClock  in  1  clock, rising edge
iReset  in  1  asynchronous active-low reset
pM0_ar_valid  in  1  M0 read address valid
pM0_ar_bits_addr  in  ADDR_WIDTH  M0 read address
pM0_ar_ready  out  1  M0 read address accepted
pM0_r_ready  in  1  M0 ready for read data
pM0_r_valid  out  1  M0 read data valid
pM0_r_bits_data  out  DATA_WIDTH  M0 read data
pM0_r_bits_resp  out  RESP_WIDTH  M0 read response
pM1_ar_valid / pM1_ar_bits_addr / pM1_ar_ready / pM1_r_ready / pM1_r_valid / pM1_r_bits_data / pM1_r_bits_resp  same as M0, for M1
pS_ar_valid  out  1  slave read address valid
pS_ar_bits_addr  out  ADDR_WIDTH  slave read address (registered)
pS_ar_ready  in  1  slave accepts address
pS_r_valid  in  1  slave read data valid
pS_r_bits_data  in  DATA_WIDTH  slave read data
pS_r_bits_resp  in  RESP_WIDTH  slave read response
pS_r_ready  out  1  arbiter ready for slave data

Behaviour:
- Reset:
  - iReset low asynchronously forces state IDLE, r_grant=0, r_last=1 (M0 wins first tie), r_addr=0, r_live=0.
  - All valid/ready outputs are 0 while reset is asserted; data/resp outputs are 0.
- r_live:
  - Set on the first clock edge after iReset deasserts.
  - All pMx_ar_ready are gated by r_live, so no address is accepted in the release cycle.
- States: IDLE, ADDR, DATA.
- IDLE:
  - Combinational winner each cycle:
    - Only one ar_valid high: that master wins.
    - Both high: the master != r_last wins.
    - Neither high: no winner.
  - pMx_ar_ready = r_live && (winner==x); all other ready outputs are 0.
  - On the master AR handshake: latch r_addr, set r_grant=winner, go to ADDR.
  - Arbitration is recomputed every IDLE cycle. Nothing is latched without a handshake.
- ADDR:
  - pS_ar_valid=1 and pS_ar_bits_addr=r_addr.
  - Hold until pS_ar_ready; on the handshake go to DATA.
  - Earliest slave ar_valid is one cycle after the master AR handshake.
- DATA:
  - pMg_r_valid = pS_r_valid, pMg_r_bits_data/resp = slave values, pS_r_ready = pMg_r_ready (g = r_grant).
  - These are pure combinational passthroughs, with zero added latency on R.
  - On the R handshake: r_last=r_grant, go to IDLE.
- Non-granted master: r_valid=0, r_data=0, r_resp=0, ar_ready=0 outside IDLE.
- Responses are forwarded unmodified (OKAY=2'b00, SLVERR/DECERR passed through). No retry.
- Minimum turnaround: the R handshake returns to IDLE, and the next AR handshake happens in the following cycle.
  - Back-to-back reads therefore cost at least 3 cycles each (IDLE, ADDR, DATA) with a zero-wait slave.
- A master holding ar_valid while the other is mid-transaction waits. Round robin guarantees service within one other transaction.
- pS_ar_valid never deasserts before pS_ar_ready.
- pS_r_valid arriving in IDLE/ADDR is ignored (pS_r_ready=0); this is a slave protocol error and is not flagged.
- Reset mid-transaction:
  - The transaction is abandoned and all handshakes drop immediately.
  - The slave must be reset by the same iReset.

Test Plan:
- M0 only, addr 0x8000_0000, slave returns 0x0000_0013_0000_0297 OKAY after 2 wait cycles -> pM0_ar_ready in cycle 1; pS_ar_valid from cycle 2 with addr 0x8000_0000; M0 gets that data with resp 0; pM1_r_valid stays 0.
- M0 and M1 assert ar_valid together after reset (M1 addr 0x8000_1000) -> M0 granted first; M1 granted in the IDLE after M0's R handshake; pS_ar_bits_addr=0x8000_1000 on the second transaction.
- Both held continuously for 6 transactions -> grants alternate M0,M1,M0,M1,M0,M1; no master is served twice in a row.
- Slave pS_ar_ready low 5 cycles, then pS_r_valid with resp 2'b10 while pM1_r_ready low 3 cycles -> pS_ar_valid/addr stable throughout; resp 2'b10 delivered to M1 only on its ready; pS_r_ready mirrors pM1_r_ready.
- iReset low during DATA with pS_r_valid=1 -> all valid/ready outputs 0 immediately; after release, ar_ready stays 0 for one cycle (r_live), then M0 wins the next tie.
- M1 drops then reasserts ar_valid during an M0 transaction -> no M1 handshake until IDLE; pM1_r_valid=0 throughout the M0 transaction.
